// File: rtl/seq_detect_moore_param_pkg.sv
// rtl/seq_detect_moore_param_pkg.sv - shared types, default configuration and masked compare for the sequence detector
package seq_detect_pkg;

  // Two-state Moore machine: z is high only in FOUND.
  typedef enum logic {
    HUNT  = 1'b0,
    FOUND = 1'b1
  } state_t;

  // Widest pattern the masked compare can handle; callers zero-extend into it.
  localparam int CMP_W = 64;

  // Configuration restored by reset (right-aligned pattern, length, overlap).
  localparam logic [7:0] DEF_PAT_C = 8'b0000_1011;
  localparam int         DEF_LEN_C = 4;
  localparam bit         DEF_OVL_C = 1'b1;

  // True when the low 'len' bits of a and b agree; bits at or above len are ignored.
  function automatic logic masked_eq(input logic [CMP_W-1:0] a,
                                     input logic [CMP_W-1:0] b,
                                     input int               len);
    logic [CMP_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < CMP_W; i++) begin
      mask[i] = (i < len);
    end
    return (((a ^ b) & mask) == '0);
  endfunction

endpackage

// File: rtl/seq_detect_moore_param_if.sv
// rtl/seq_detect_moore_param_if.sv - serial input, configuration and result bundle for the sequence detector
interface seq_detect_moore_param_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             x_valid;
  logic             x;
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_ovl;
  logic             z;
  logic [CNT_W-1:0] match_cnt;

  // Stimulus side: drives bits and configuration, observes the result.
  modport master (
    output x_valid, x, cfg_we, cfg_pat, cfg_len, cfg_ovl,
    input  z, match_cnt
  );

  // Detector side.
  modport slave (
    input  x_valid, x, cfg_we, cfg_pat, cfg_len, cfg_ovl,
    output z, match_cnt
  );

endinterface

// File: rtl/seq_detect_moore_param_hist.sv
// rtl/seq_detect_moore_param_hist.sv - bit history shift register, fill counter and length-masked hit compare
module seq_hist_shreg
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_valid,
  input  logic             i_x,
  input  logic [PAT_W-1:0] i_pat,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_ovl,
  output logic             o_hit
);

  logic [PAT_W-1:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic [PAT_W-1:0] w_hist_next;
  logic [LEN_W-1:0] w_fill_inc;
  logic [CMP_W-1:0] w_cmp_a;
  logic [CMP_W-1:0] w_cmp_b;
  logic             w_cmp_eq;

  // Hit is judged on the history as it will look after this bit is shifted in.
  always_comb begin
    w_hist_next = {r_hist[PAT_W-2:0], i_x};
    w_fill_inc  = (r_fill == LEN_W'(PAT_W)) ? r_fill : r_fill + LEN_W'(1);
    w_cmp_a     = '0;
    w_cmp_b     = '0;
    w_cmp_a[PAT_W-1:0] = w_hist_next;
    w_cmp_b[PAT_W-1:0] = i_pat;
    w_cmp_eq    = masked_eq(w_cmp_a, w_cmp_b, int'(i_len));
    // A configuration load in the same cycle drops the bit, so it can never hit.
    o_hit       = i_valid && !i_clr && (i_len != '0) &&
                  (w_fill_inc >= i_len) && w_cmp_eq;
  end

  // Shift in valid bits; non-overlapping mode restarts the fill after a hit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_valid) begin
      r_hist <= w_hist_next;
      r_fill <= (o_hit && !i_ovl) ? '0 : w_fill_inc;
    end
  end

endmodule

// File: rtl/seq_detect_moore_param.sv
// rtl/seq_detect_moore_param.sv - programmable Moore sequence detector top; optional match counter under SEQDET_MATCH_CNT_EN
module seq_detect_moore_param
  import seq_detect_pkg::*;
#(
  parameter int             PAT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PAT_C),
  parameter int             DEF_LEN = DEF_LEN_C,
  parameter bit             DEF_OVL = DEF_OVL_C,
  parameter int             CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  seq_detect_moore_param_if.slave bus
);

  localparam int LEN_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic             r_ovl;
  logic [LEN_W-1:0] w_len_clamp;
  logic             w_hit;
  state_t           r_state;
  state_t           w_state_next;

  // Lengths beyond the history depth are clamped when loaded.
  always_comb begin
    w_len_clamp = bus.cfg_len;
    if (int'(bus.cfg_len) > PAT_W) begin
      w_len_clamp = LEN_W'(PAT_W);
    end
  end

  // Configuration registers, reloaded as a unit by cfg_we.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pat <= DEF_PAT;
      r_len <= LEN_W'(DEF_LEN);
      r_ovl <= DEF_OVL;
    end else if (bus.cfg_we) begin
      r_pat <= bus.cfg_pat;
      r_len <= w_len_clamp;
      r_ovl <= bus.cfg_ovl;
    end
  end

  seq_hist_shreg #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_hist (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (bus.cfg_we),
    .i_valid (bus.x_valid),
    .i_x     (bus.x),
    .i_pat   (r_pat),
    .i_len   (r_len),
    .i_ovl   (r_ovl),
    .o_hit   (w_hit)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: FOUND persists only while hits keep arriving; cfg_we forces HUNT.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      HUNT:    w_state_next = w_hit ? FOUND : HUNT;
      FOUND:   w_state_next = w_hit ? FOUND : HUNT;
      default: w_state_next = HUNT;
    endcase
    if (bus.cfg_we) begin
      w_state_next = HUNT;
    end
  end

  assign bus.z = (r_state == FOUND);

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Saturating hit counter, cleared with each configuration load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (bus.cfg_we) begin
      r_cnt <= '0;
    end else if (w_hit && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.match_cnt = r_cnt;
`else
  assign bus.match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// tb/tb_seq_detect_moore_param.sv - directed self-checking bench for seq_detect_moore_param
module tb_seq_detect_moore_param;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
`ifdef SEQDET_MATCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  seq_detect_moore_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_detect_moore_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ecnt(input int n);
    return CNT_ON ? 32'(n) : 32'd0;
  endfunction

  // One clock with the given inputs; returns 1 ns after the edge.
  task automatic step(input logic v, input logic b);
    bus.x_valid = v;
    bus.x       = b;
    @(posedge clk);
    #1;
    bus.x_valid = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    bus.cfg_we  = 1'b1;
    bus.cfg_pat = p;
    bus.cfg_len = l;
    bus.cfg_ovl = o;
    @(posedge clk);
    #1;
    bus.cfg_we  = 1'b0;
  endtask

  // Send a bit string (MSB first, n bits) and compare z after each bit.
  task automatic stream(input string tag, input logic [31:0] bits,
                        input logic [31:0] zexp, input int n);
    logic [31:0] b;
    logic [31:0] e;
    b = bits;
    e = zexp;
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, b[i]);
      chk($sformatf("%s_z_bit%0d", tag, n - i), 32'(bus.z), 32'(e[i]));
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.x_valid = 1'b0;
    bus.x       = 1'b0;
    bus.cfg_we  = 1'b0;
    bus.cfg_pat = '0;
    bus.cfg_len = '0;
    bus.cfg_ovl = 1'b0;
    reset_n     = 1'b0;
    #2;
    chk("reset_z", 32'(bus.z), 32'd0);
    chk("reset_cnt", 32'(bus.match_cnt), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Default 1011 overlapping: hits after bits 4 and 7.
    stream("ovl", 32'b1011011, 32'b0001001, 7);
    chk("ovl_cnt", 32'(bus.match_cnt), ecnt(2));
    step(1'b0, 1'b0);
    chk("ovl_exit", 32'(bus.z), 32'd0);

    // Non-overlapping, high pattern bits set but ignored: only the first hit.
    cfg(8'b1111_1011, 4'd4, 1'b0);
    chk("cfg_z", 32'(bus.z), 32'd0);
    chk("cfg_cnt_clr", 32'(bus.match_cnt), 32'd0);
    stream("novl", 32'b1011011, 32'b0001000, 7);
    chk("novl_cnt", 32'(bus.match_cnt), ecnt(1));

    // Full-length all-ones pattern: hits after bits 8 and 9, z held two cycles.
    cfg(8'hFF, 4'd8, 1'b1);
    stream("ones", 32'b111111111, 32'b000000011, 9);
    chk("ones_cnt", 32'(bus.match_cnt), ecnt(2));
    step(1'b0, 1'b0);
    chk("ones_exit", 32'(bus.z), 32'd0);

    // Length above PAT_W clamps to 8.
    cfg(8'hFF, 4'd15, 1'b1);
    stream("clamp", 32'hFF, 32'h01, 8);

    // Length zero never matches.
    cfg(8'h00, 4'd0, 1'b1);
    stream("len0", 32'b0000, 32'b0000, 4);
    chk("len0_cnt", 32'(bus.match_cnt), 32'd0);

    // Default config with gaps of x_valid=0 inside the pattern.
    do_reset();
    stream("gap_a", 32'b101, 32'b000, 3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      chk($sformatf("gap_idle%0d", i), 32'(bus.z), 32'd0);
    end
    step(1'b1, 1'b1);
    chk("gap_hit", 32'(bus.z), 32'd1);
    step(1'b0, 1'b0);
    chk("gap_found_exit", 32'(bus.z), 32'd0);

    // cfg_we collides with the final pattern bit: bit dropped, history cleared.
    cfg(8'b0000_1011, 4'd4, 1'b1);
    stream("coll_a", 32'b101, 32'b000, 3);
    bus.x_valid = 1'b1;
    bus.x       = 1'b1;
    cfg(8'b0000_1011, 4'd4, 1'b1);
    bus.x_valid = 1'b0;
    chk("coll_z", 32'(bus.z), 32'd0);
    chk("coll_cnt", 32'(bus.match_cnt), 32'd0);
    stream("coll_b", 32'b011, 32'b000, 3);

    // Five overlapping 0110 hits, then asynchronous reset while z=1.
    cfg(8'b0000_0110, 4'd4, 1'b1);
    stream("five", 32'b0110110110110110, 32'b0001001001001001, 16);
    chk("five_cnt", 32'(bus.match_cnt), ecnt(5));
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_z", 32'(bus.z), 32'd0);
    chk("arst_cnt", 32'(bus.match_cnt), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    stream("arst_def", 32'b1011, 32'b0001, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
